chip8_mem_seq: RTL and testbench
================================

# chip8_mem_seq

Memory access sequencer that acts as the initiator for `chip8_mem`, the 4 KiB byte memory. It accepts one request at a time from the CPU core: a 16-bit opcode fetch, a byte-burst read (sprite rows, FX65), or a byte-burst write (FX55, FX33 BCD). It drives the memory's `read`/`write`/address/data pins. It also enforces the memory's rule that any cycle with `read` low is a write.

## Interface
Parameters:
- `ADDR_W`, 12: memory address width. Addresses wrap modulo 2^ADDR_W.

Ports:
- `clk`, in, 1: single clock; all logic on posedge.
- `reset`, in, 1: synchronous, active-high.
- `req_valid`, in, 1: request strobe.
- `req_ready`, out, 1: `(state==IDLE) && !reset`.
- `req_op`, in, 2: 00 FETCH, 01 READ, 10 WRITE, 11 NOP.
- `req_addr`, in, ADDR_W: start address.
- `req_len`, in, 4: burst length N = `req_len`+1 (1..16). Ignored for FETCH.
- `wr_data`, in, 8: write byte.
- `wr_valid`, in, 1: write byte available.
- `wr_ready`, out, 1: high while in WRITE state.
- `rd_data`, out, 8: `mem_data_out` passthrough.
- `rd_valid`, out, 1: `rd_data` holds a READ burst byte.
- `opcode`, out, 16: assembled fetch result, {byte@A, byte@A+1}.
- `opcode_valid`, out, 1: one-cycle pulse.
- `busy`, out, 1: `!req_ready`.
- `mem_read`, out, 1: to memory `read`. Must be 1 except on write cycles.
- `mem_write`, out, 1: `~mem_read`. The memory ignores it; it is for debug.
- `mem_address`, out, ADDR_W: to memory `mem_address`.
- `mem_data_in`, out, 8: to memory `mem_data_in`.
- `mem_data_out`, in, 8: from memory. Registered; valid one cycle after the address is presented.

## Operation
- States: IDLE, ISSUE, DRAIN, WRITE, DONE.
- IDLE:
  - `mem_read`=1.
  - A handshake (`req_valid && req_ready`) latches op, address, and N, and clears the byte counter.
  - FETCH sets N=2. FETCH and READ go to ISSUE. WRITE goes to WRITE. NOP goes to DONE.
- ISSUE:
  - Presents address A+k with `mem_read`=1, and increments k each cycle.
  - After issuing N addresses, goes to DRAIN.
  - `rd_valid` is a one-cycle-delayed copy of "issued a READ address last cycle". It is never set for FETCH.
- DRAIN: the last byte returns, then go to DONE.
- FETCH assembly: the byte returned for k=0 is latched as opcode[15:8]. The byte for k=1 is registered with it into `opcode` at the end of DRAIN.
- DONE:
  - `opcode_valid`=1 for FETCH only.
  - `req_ready` is high in this cycle (DONE counts as IDLE for acceptance). Back-to-back requests are allowed.
- WRITE:
  - Each cycle with `wr_valid`: `mem_read`=0, `mem_address`=A+k, `mem_data_in`=`wr_data`, k++.
  - Cycles without `wr_valid` are a stall: `mem_read`=1 and no write occurs.
  - After the Nth byte, go to IDLE.
- Address arithmetic is 12-bit wrap: 0xFFF+1 = 0x000. No alignment requirement; odd fetch addresses are legal.
- `req_valid` while busy is ignored, not queued.

## Timing
Cycle 0 is the handshake cycle.
- READ, length N:
  - Addresses are presented in cycles 1..N.
  - `rd_valid` is high with data in cycles 2..N+1.
  - `req_ready` is high again in cycle N+2.
- FETCH:
  - Addresses in cycles 1–2.
  - `opcode_valid` and `req_ready` in cycle 4.
- WRITE, no stalls: memory writes in cycles 1..N, `req_ready` in cycle N+1. Each stall cycle adds one.
- NOP: `req_ready` in cycle 2.
- Reset values:
  - State IDLE. All counters 0.
  - `mem_read`=1 (forced combinationally while `reset` is high).
  - `mem_write`=0, `mem_address`=0, `mem_data_in`=0.
  - `rd_valid`=0, `opcode`=0, `opcode_valid`=0, `wr_ready`=0, `req_ready`=0.
- Reset mid-operation: abort immediately. No memory write occurs in the reset cycle or afterwards. Bytes already written stay written. `req_ready`=1 in the first cycle after reset deasserts.

## Structure
- `chip8_pkg` holds:
  - Op encodings.
  - `CHIP8_ADDR_W`=12 and `CHIP8_MEM_SIZE`=4096.
  - `FONT_BASE`=12'h000, `FONT_STRIDE`=5, `PROG_BASE`=12'h200.
  - The state enum.
- Single FSM module; no sub-module needed.
- The bench instantiates this block against `chip8_mem` directly.

## Test plan
- FETCH at 0x200, with the game image holding 0x00, 0xE0: `opcode`=0x00E0 and `opcode_valid` in cycle 4 only. Addresses 0x200 then 0x201 in cycles 1–2.
- READ at 0x005 with `req_len`=4 (font "1"): `rd_data` = 20, 60, 20, 20, 70 on cycles 2–6 with `rd_valid`. `req_ready` in cycle 7.
- WRITE at 0x300 with N=3, bytes 01, 02, 03, and `wr_valid` low for one cycle after the first byte: exactly 3 write cycles and `mem_read`=1 on the stall cycle. A READ of 0x2FF..0x303 returns the old value, 01, 02, 03, old value.
- FETCH at 0xFFF: opcode[15:8]=mem[0xFFF] and opcode[7:0]=mem[0x000]=0xF0.
- WRITE at 0x310 with N=4, `reset` asserted after 2 bytes: only 0x310–0x311 change, `mem_read`=1 in the reset cycle, and `req_ready`=1 the cycle after reset.
- 100 idle cycles plus `req_valid` pulses while busy: `mem_read` stays 1 throughout idle, memory contents are unchanged, and only one request is serviced.

Source files
------------

// File: rtl/chip8_pkg.sv
// rtl/chip8_pkg.sv - shared CHIP-8 memory constants, op encodings and sequencer states
package chip8_pkg;

    localparam int CHIP8_ADDR_W   = 12;
    localparam int CHIP8_MEM_SIZE = 4096;

    localparam logic [11:0] FONT_BASE   = 12'h000;
    localparam int          FONT_STRIDE = 5;
    localparam logic [11:0] PROG_BASE   = 12'h200;

    typedef enum logic [1:0] {
        OP_FETCH = 2'b00,
        OP_READ  = 2'b01,
        OP_WRITE = 2'b10,
        OP_NOP   = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_WRITE,
        ST_DONE
    } state_e;

    // A fetch is always a two-byte burst; other ops use the requested length.
    function automatic logic [3:0] burst_last(input op_e op, input logic [3:0] len);
        return (op == OP_FETCH) ? 4'd1 : len;
    endfunction

endpackage

// File: rtl/chip8_mem_seq_if.sv
// rtl/chip8_mem_seq_if.sv - request, write, read and memory-pin bundle of the sequencer
interface chip8_mem_seq_if #(parameter int ADDR_W = 12) ();

    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_op;
    logic [ADDR_W-1:0] req_addr;
    logic [3:0]        req_len;
    logic [7:0]        wr_data;
    logic              wr_valid;
    logic              wr_ready;
    logic [7:0]        rd_data;
    logic              rd_valid;
    logic [15:0]       opcode;
    logic              opcode_valid;
    logic              busy;
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_address;
    logic [7:0]        mem_data_in;
    logic [7:0]        mem_data_out;

    modport master (
        input  req_valid, req_op, req_addr, req_len, wr_data, wr_valid, mem_data_out,
        output req_ready, wr_ready, rd_data, rd_valid, opcode, opcode_valid, busy,
               mem_read, mem_write, mem_address, mem_data_in
    );

    modport slave (
        output req_valid, req_op, req_addr, req_len, wr_data, wr_valid, mem_data_out,
        input  req_ready, wr_ready, rd_data, rd_valid, opcode, opcode_valid, busy,
               mem_read, mem_write, mem_address, mem_data_in
    );

endinterface

// File: rtl/chip8_mem_seq.sv
// rtl/chip8_mem_seq.sv - one-request-at-a-time initiator for the 4 KiB CHIP-8 byte memory
module chip8_mem_seq
    import chip8_pkg::*;
#(
    parameter int ADDR_W = CHIP8_ADDR_W
) (
    input  logic             clk,
    input  logic             reset,
    chip8_mem_seq_if.master  bus
);

    state_e            state_q, state_d;
    op_e               op_q, op_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [3:0]        last_q, last_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [7:0]        hi_q, hi_d;
    logic [15:0]       opcode_q, opcode_d;
    logic              rd_valid_q, rd_valid_d;

    logic              req_ready_w;
    logic              accept;
    logic              wr_fire;
    logic              cnt_end;
    logic [ADDR_W-1:0] cur_addr;

    // A NOP spends its DONE cycle as a plain turnaround, so it is not ready there.
    assign req_ready_w = ((state_q == ST_IDLE) || (state_q == ST_DONE && op_q != OP_NOP)) && !reset;
    assign accept      = bus.req_valid && req_ready_w;
    assign wr_fire     = (state_q == ST_WRITE) && bus.wr_valid && !reset;
    assign cnt_end     = (cnt_q == last_q);
    assign cur_addr    = base_q + ADDR_W'(cnt_q);

    assign bus.req_ready = req_ready_w;
    assign bus.busy      = !req_ready_w;
    assign bus.mem_write = ~bus.mem_read;
    assign bus.rd_data   = bus.mem_data_out;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.opcode    = opcode_q;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic: DONE accepts a new request exactly like IDLE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (accept) begin
                    unique case (op_e'(bus.req_op))
                        OP_FETCH, OP_READ: state_d = ST_ISSUE;
                        OP_WRITE:          state_d = ST_WRITE;
                        default:           state_d = ST_DONE;
                    endcase
                end
            end
            ST_ISSUE: if (cnt_end) state_d = ST_DRAIN;
            ST_DRAIN: state_d = ST_DONE;
            ST_WRITE: if (wr_fire && cnt_end) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Request latch, byte counter, fetch assembly and read-valid delay.
    always_comb begin
        op_d       = op_q;
        base_d     = base_q;
        last_d     = last_q;
        cnt_d      = cnt_q;
        hi_d       = hi_q;
        opcode_d   = opcode_q;
        rd_valid_d = (state_q == ST_ISSUE) && (op_q == OP_READ);
        if (accept) begin
            op_d   = op_e'(bus.req_op);
            base_d = bus.req_addr;
            last_d = burst_last(op_e'(bus.req_op), bus.req_len);
            cnt_d  = 4'd0;
        end else if (state_q == ST_ISSUE || wr_fire) begin
            cnt_d = cnt_q + 4'd1;
        end
        // The byte for k=0 is on the memory output while k=1 is being issued.
        if (state_q == ST_ISSUE && op_q == OP_FETCH && cnt_q == 4'd1) hi_d = bus.mem_data_out;
        if (state_q == ST_DRAIN && op_q == OP_FETCH) opcode_d = {hi_q, bus.mem_data_out};
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_q       <= OP_FETCH;
            base_q     <= '0;
            last_q     <= 4'd0;
            cnt_q      <= 4'd0;
            hi_q       <= 8'd0;
            opcode_q   <= 16'd0;
            rd_valid_q <= 1'b0;
        end else begin
            op_q       <= op_d;
            base_q     <= base_d;
            last_q     <= last_d;
            cnt_q      <= cnt_d;
            hi_q       <= hi_d;
            opcode_q   <= opcode_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    // Memory pins and status outputs; mem_read drops only on a real write cycle.
    always_comb begin
        bus.mem_read     = 1'b1;
        bus.mem_address  = '0;
        bus.mem_data_in  = 8'd0;
        bus.wr_ready     = 1'b0;
        bus.opcode_valid = 1'b0;
        if (!reset) begin
            unique case (state_q)
                ST_ISSUE: bus.mem_address = cur_addr;
                ST_WRITE: begin
                    bus.wr_ready = 1'b1;
                    if (bus.wr_valid) begin
                        bus.mem_read    = 1'b0;
                        bus.mem_address = cur_addr;
                        bus.mem_data_in = bus.wr_data;
                    end
                end
                ST_DONE:  bus.opcode_valid = (op_q == OP_FETCH);
                default:  ;
            endcase
        end
    end

endmodule

// File: tb/tb_chip8_mem_seq.sv
// tb/tb_chip8_mem_seq.sv - randomized self-checking bench for chip8_mem_seq with a byte-memory model
module tb_chip8_mem_seq;
    import chip8_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    chip8_mem_seq_if #(.ADDR_W(12)) bus ();

    chip8_mem_seq #(.ADDR_W(12)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [7:0] mem     [0:4095];
    logic [7:0] ref_mem [0:4095];
    bit         loaded = 1'b0;

    // Byte memory: registered read, any cycle with read low writes.
    always @(posedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < 4096; i++) mem[i] <= ref_mem[i];
            loaded <= 1'b1;
        end else if (!bus.mem_read) begin
            mem[bus.mem_address] <= bus.mem_data_in;
        end
        bus.mem_data_out <= mem[bus.mem_address];
    end

    int          errors = 0;
    int          checks = 0;
    logic        exp_opv = 1'b0;
    logic [15:0] exp_opcode = 16'h0000;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic busy_inputs();
        reset         = 1'b0;
        bus.req_valid = 1'($urandom_range(0, 1));
        bus.req_op    = 2'($urandom);
        bus.req_addr  = 12'($urandom);
        bus.req_len   = 4'($urandom);
    endtask

    // One cycle where the sequencer must be ready; optionally issues a request.
    task automatic ready_cycle(input bit req, input logic [1:0] op, input logic [11:0] a, input logic [3:0] len);
        @(negedge clk);
        reset         = 1'b0;
        bus.wr_valid  = 1'b0;
        bus.wr_data   = 8'($urandom);
        bus.req_valid = req;
        bus.req_op    = op;
        bus.req_addr  = a;
        bus.req_len   = len;
        #1;
        check_eq("req_ready", bus.req_ready, 1);
        check_eq("busy", bus.busy, 0);
        check_eq("idle_mem_read", bus.mem_read, 1);
        check_eq("idle_rd_valid", bus.rd_valid, 0);
        check_eq("idle_wr_ready", bus.wr_ready, 0);
        check_eq("opcode_valid", bus.opcode_valid, exp_opv);
        check_eq("opcode", bus.opcode, exp_opcode);
        exp_opv = 1'b0;
        @(posedge clk);
    endtask

    task automatic do_fetch(input logic [11:0] a);
        ready_cycle(1'b1, OP_FETCH, a, 4'($urandom));
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            busy_inputs();
            #1;
            check_eq("f_mem_read", bus.mem_read, 1);
            if (c <= 2) check_eq("f_addr", bus.mem_address, 12'(a + 12'(c - 1)));
            check_eq("f_rd_valid", bus.rd_valid, 0);
            check_eq("f_opc_valid", bus.opcode_valid, 0);
            check_eq("f_req_ready", bus.req_ready, 0);
            @(posedge clk);
        end
        exp_opv    = 1'b1;
        exp_opcode = {ref_mem[a], ref_mem[12'(a + 12'd1)]};
    endtask

    task automatic do_read(input logic [11:0] a, input logic [3:0] len);
        int n;
        n = int'(len) + 1;
        ready_cycle(1'b1, OP_READ, a, len);
        for (int c = 1; c <= n + 1; c++) begin
            @(negedge clk);
            busy_inputs();
            #1;
            check_eq("r_mem_read", bus.mem_read, 1);
            if (c <= n) check_eq("r_addr", bus.mem_address, 12'(a + 12'(c - 1)));
            check_eq("r_rd_valid", bus.rd_valid, (c >= 2) ? 1 : 0);
            if (c >= 2) check_eq("r_rd_data", bus.rd_data, ref_mem[12'(a + 12'(c - 2))]);
            check_eq("r_opc_valid", bus.opcode_valid, 0);
            check_eq("r_req_ready", bus.req_ready, 0);
            @(posedge clk);
        end
    endtask

    task automatic do_write(input logic [11:0] a, input logic [3:0] len, input logic [127:0] wd,
                            input logic [15:0] stall_mask, input int abort_after);
        int n, j, wcount;
        n      = int'(len) + 1;
        j      = 0;
        wcount = 0;
        ready_cycle(1'b1, OP_WRITE, a, len);
        while (j < n) begin
            if (j == abort_after) begin
                @(negedge clk);
                busy_inputs();
                reset        = 1'b1;
                bus.wr_valid = 1'b1;
                bus.wr_data  = wd[j*8 +: 8];
                #1;
                check_eq("abort_mem_read", bus.mem_read, 1);
                check_eq("abort_mem_write", bus.mem_write, 0);
                check_eq("abort_req_ready", bus.req_ready, 0);
                @(posedge clk);
                exp_opcode = 16'h0000;
                break;
            end
            if (stall_mask[j]) begin
                @(negedge clk);
                busy_inputs();
                bus.wr_valid = 1'b0;
                bus.wr_data  = 8'($urandom);
                #1;
                check_eq("w_stall_mem_read", bus.mem_read, 1);
                check_eq("w_stall_wr_ready", bus.wr_ready, 1);
                check_eq("w_stall_req_ready", bus.req_ready, 0);
                if (!bus.mem_read) wcount++;
                @(posedge clk);
            end
            @(negedge clk);
            busy_inputs();
            bus.wr_valid = 1'b1;
            bus.wr_data  = wd[j*8 +: 8];
            #1;
            check_eq("w_wr_ready", bus.wr_ready, 1);
            check_eq("w_mem_write", bus.mem_write, 1);
            check_eq("w_addr", bus.mem_address, 12'(a + 12'(j)));
            check_eq("w_data_in", bus.mem_data_in, wd[j*8 +: 8]);
            check_eq("w_req_ready", bus.req_ready, 0);
            if (!bus.mem_read) wcount++;
            ref_mem[12'(a + 12'(j))] = wd[j*8 +: 8];
            j++;
            @(posedge clk);
        end
        check_eq("w_count", wcount, (abort_after >= 0 && abort_after < n) ? abort_after : n);
    endtask

    task automatic do_nop();
        ready_cycle(1'b1, OP_NOP, 12'($urandom), 4'($urandom));
        @(negedge clk);
        busy_inputs();
        #1;
        check_eq("n_req_ready", bus.req_ready, 0);
        check_eq("n_mem_read", bus.mem_read, 1);
        check_eq("n_opc_valid", bus.opcode_valid, 0);
        @(posedge clk);
    endtask

    task automatic check_image(input string tag);
        int bad;
        bad = 0;
        for (int i = 0; i < 4096; i++) if (mem[i] !== ref_mem[i]) bad++;
        check_eq(tag, bad, 0);
    endtask

    initial begin
        logic [79:0] font01;
        logic [11:0] a;
        logic [3:0]  len;
        font01 = 80'hF0909090F0_2060202070;
        for (int i = 0; i < 4096; i++) ref_mem[i] = 8'($urandom);
        for (int i = 0; i < 10; i++) ref_mem[FONT_BASE + 12'(i)] = font01[79 - 8*i -: 8];
        ref_mem[PROG_BASE]         = 8'h00;
        ref_mem[PROG_BASE + 12'd1] = 8'h E0;

        reset         = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_op    = OP_NOP;
        bus.req_addr  = 12'h000;
        bus.req_len   = 4'd0;
        bus.wr_valid  = 1'b0;
        bus.wr_data   = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b1;
        #1;
        check_eq("rst_mem_read", bus.mem_read, 1);
        check_eq("rst_mem_write", bus.mem_write, 0);
        check_eq("rst_mem_address", bus.mem_address, 0);
        check_eq("rst_mem_data_in", bus.mem_data_in, 0);
        check_eq("rst_req_ready", bus.req_ready, 0);
        check_eq("rst_rd_valid", bus.rd_valid, 0);
        check_eq("rst_opcode", bus.opcode, 0);
        check_eq("rst_opcode_valid", bus.opcode_valid, 0);
        check_eq("rst_wr_ready", bus.wr_ready, 0);
        @(posedge clk);
        ready_cycle(1'b0, OP_NOP, 12'h000, 4'd0);

        do_fetch(PROG_BASE);
        check_eq("fetch_200_model", exp_opcode, 16'h00E0);
        do_read(FONT_BASE + 12'(FONT_STRIDE), 4'd4);
        do_write(12'h300, 4'd2, 128'h030201, 16'h0002, -1);
        ready_cycle(1'b0, OP_NOP, 12'h000, 4'd0);
        do_read(12'h2FF, 4'd4);
        do_fetch(12'hFFF);
        ready_cycle(1'b0, OP_NOP, 12'h000, 4'd0);
        do_write(12'h310, 4'd3, 128'hDDCCBBAA, 16'h0000, 2);
        ready_cycle(1'b0, OP_NOP, 12'h000, 4'd0);
        check_image("image_after_abort");

        for (int i = 0; i < 100; i++) ready_cycle(1'b0, 2'($urandom), 12'($urandom), 4'($urandom));
        check_image("image_after_idle");

        for (int t = 0; t < 40; t++) begin
            a   = ($urandom_range(0, 3) == 0) ? (12'hFF0 | 12'($urandom_range(0, 15))) : 12'($urandom);
            len = 4'($urandom);
            case ($urandom_range(0, 3))
                0: do_fetch(a);
                1: do_read(a, len);
                2: do_write(a, len, {$urandom, $urandom, $urandom, $urandom},
                            16'($urandom & $urandom), -1);
                default: do_nop();
            endcase
            if ($urandom_range(0, 1) == 1) ready_cycle(1'b0, OP_NOP, 12'h000, 4'd0);
        end
        ready_cycle(1'b0, OP_NOP, 12'h000, 4'd0);
        check_image("image_final");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
